arb_mux81: RTL and testbench

- Round-robin arbiter that shares the single-bit 8:1 multiplexer output channel between 8 requesters.
- Accepts one request line per mux input and grants exactly one owner at a time.
- Drives the mux 3-bit select in the mux's native bit order, plus a one-hot grant and a busy flag.
- Sits directly in front of the 8:1 mux; the mux data inputs a..h correspond to requester indices 0..7.

---
 rtl/arb_mux81_pkg.sv | 27 ++
 rtl/arb_mux81_rr_pick.sv | 31 +++
 rtl/arb_mux81.sv | 137 +++++++++++++
 tb/tb_arb_mux81.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux81_pkg.sv
// Shared types and constants for the arb_mux81 round-robin arbiter.
// Holds requester count, index width, FSM state encoding, the registered
// output bundle and the bit-reversed mux select mapping.
package arb_mux81_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Registered output bundle driven toward the 8:1 mux.
    typedef struct packed {
        logic [NUM_REQ-1:0] gnt;
        logic [IDX_W-1:0]   sel;
        logic               busy;
    } arb_out_t;

    // The mux expects its select bits in reverse order of the requester index.
    function automatic logic [IDX_W-1:0] sel_map(input logic [IDX_W-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/arb_mux81_rr_pick.sv
// Combinational round-robin picker.
// Ports: req   - request vector
//        start - first index to examine; scan wraps modulo NUM_REQ
//        found - any request asserted
//        idx   - index of the first asserted request at or after start
module arb_mux81_rr_pick
    import arb_mux81_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = start + IDX_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/arb_mux81.sv
// Round-robin arbiter sharing an 8:1 mux output between 8 requesters.
// Optional lock input guarded by macro ARB_LOCK_EN: while the current owner
// keeps requesting with lock high, the HOLD_MAX forced handoff is suppressed.
// Ports: clk  - rising-edge clock
//        rst  - synchronous active-high reset
//        req  - request per requester (bit i = mux input i)
//        lock - (ARB_LOCK_EN only) hold the channel past HOLD_MAX
//        gnt  - registered one-hot grant
//        sel  - registered mux select, bit-reversed owner index
//        busy - registered, high while a grant is active
module arb_mux81
    import arb_mux81_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
`ifdef ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   sel,
    output logic               busy
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    arb_out_t         out_q, out_d;

    logic               lock_act;
    logic               hold_hit;
    logic [IDX_W-1:0]   owner_next;
    logic [NUM_REQ-1:0] pick_req;
    logic [IDX_W-1:0]   pick_start;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               take;

`ifdef ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    assign hold_hit   = (cnt_q == CNT_W'(HOLD_MAX));
    assign owner_next = owner_q + IDX_W'(1);

    // Idle scans from ptr; a handoff scans from owner+1 excluding the owner.
    assign pick_req   = req & ~out_q.gnt;
    assign pick_start = (state_q == ST_GRANT) ? owner_next : ptr_q;

    arb_mux81_rr_pick u_pick (
        .req   (pick_req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        take    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    take = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!req[owner_q]) begin
                    ptr_d = owner_next;
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        out_d.gnt  = '0;
                        out_d.busy = 1'b0;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end
                end else if (hold_hit && !lock_act) begin
                    if (pick_found) begin
                        take  = 1'b1;
                        ptr_d = owner_next;
                    end else begin
                        // Nobody waiting: restart the window, grant unchanged.
                        cnt_d = CNT_W'(1);
                    end
                end else if (!hold_hit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // hold_hit with lock: counter stays saturated at HOLD_MAX.
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            owner_d    = pick_idx;
            out_d.gnt  = NUM_REQ'(1) << pick_idx;
            out_d.sel  = sel_map(pick_idx);
            out_d.busy = 1'b1;
            cnt_d      = CNT_W'(1);
            state_d    = ST_GRANT;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign gnt  = out_q.gnt;
    assign sel  = out_q.sel;
    assign busy = out_q.busy;

endmodule

// File: tb/tb_arb_mux81.sv
// Scoreboard bench for arb_mux81: stimulus pushes model-predicted outputs,
// a monitor pops and compares after every rising edge.
module tb_arb_mux81;

    localparam int HOLD = 4;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       lock = 1'b0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    // Reference model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;
    logic [2:0] m_sel;

    logic [2:0] sel_tab [8];

    always #5 clk = ~clk;

    arb_mux81 #(.HOLD_MAX(HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
`ifdef ARB_LOCK_EN
        .lock (lock),
`endif
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    function automatic int m_pick(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [2:0] m_rev(input int o);
        return 3'(((o & 1) << 2) | (o & 2) | ((o >> 2) & 1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req_v, $time);
        end
    endtask

    // Advance the model by one edge with the given inputs.
    task automatic model_step(input logic [7:0] r, input logic rs, input logic lk);
        logic [7:0] others;
        int p;
        if (rs) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_sel = 3'b000;
            return;
        end
        if (!m_busy) begin
            p = m_pick(r, m_ptr);
            if (p >= 0) begin
                m_busy = 1; m_owner = p; m_cnt = 1;
            end
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                m_ptr = (m_owner + 1) % 8;
                p = m_pick(others, m_ptr);
                if (p >= 0) begin m_owner = p; m_cnt = 1; end
                else begin m_busy = 0; m_cnt = 0; end
            end else if (m_cnt == HOLD && !lk) begin
                if (others != 0) begin
                    m_ptr = (m_owner + 1) % 8;
                    m_owner = m_pick(others, m_ptr);
                end
                m_cnt = 1;
            end else if (m_cnt < HOLD) begin
                m_cnt++;
            end
        end
        if (m_busy) m_sel = m_rev(m_owner);
    endtask

    // Drive one cycle (called at negedge), predict, and wait for the next negedge.
    task automatic cyc(input logic [7:0] r, input logic rs, input logic lk);
        exp_t e;
        req  = r;
        rst  = rs;
`ifdef ARB_LOCK_EN
        lock = lk;
        model_step(r, rs, lk);
`else
        lock = 1'b0;
        model_step(r, rs, 1'b0);
`endif
        e.gnt  = m_busy ? 8'(1 << m_owner) : 8'h00;
        e.sel  = m_sel;
        e.busy = m_busy;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare every registered output against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("gnt", 32'(gnt), 32'(e.gnt));
                check("sel", 32'(sel), 32'(e.sel));
                check("busy", 32'(busy), 32'(e.busy));
                check("busy_eq_or_gnt", 32'(busy), 32'(|gnt));
                check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            end
        end
    end

    initial begin
        logic [7:0] r;
        sel_tab[0] = 3'b000; sel_tab[1] = 3'b100; sel_tab[2] = 3'b010; sel_tab[3] = 3'b110;
        sel_tab[4] = 3'b001; sel_tab[5] = 3'b101; sel_tab[6] = 3'b011; sel_tab[7] = 3'b111;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_sel = 3'b000;

        @(negedge clk);
        repeat (3) cyc(8'h00, 1'b1, 1'b0);
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // Reset mid-grant
        repeat (6) cyc(8'hFF, 1'b0, 1'b0);
        cyc(8'hFF, 1'b1, 1'b0);
        check("rst_mid_gnt", 32'(gnt), 32'h0);
        check("rst_mid_sel", 32'(sel), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        cyc(8'h01, 1'b0, 1'b0);
        check("post_rst_gnt", 32'(gnt), 32'h01);
        check("post_rst_sel", 32'(sel), 32'h0);
        repeat (2) cyc(8'h00, 1'b0, 1'b0);

        // Select encoding, one requester at a time
        for (int i = 0; i < 8; i++) begin
            cyc(8'(1 << i), 1'b0, 1'b0);
            check("enc_gnt", 32'(gnt), 32'(1 << i));
            check("enc_sel", 32'(sel), 32'(sel_tab[i]));
            cyc(8'h00, 1'b0, 1'b0);
            check("enc_idle_sel_hold", 32'(sel), 32'(sel_tab[i]));
        end

        // Fairness with everyone requesting
        repeat (40) cyc(8'hFF, 1'b0, 1'b0);
        repeat (2) cyc(8'h00, 1'b0, 1'b0);

        // Early release: owner 2 drops, 0 and 7 pending -> 7
        cyc(8'h04, 1'b0, 1'b0);
        check("early_owner2", 32'(gnt), 32'h04);
        cyc(8'h85, 1'b0, 1'b0);
        cyc(8'h81, 1'b0, 1'b0);
        check("early_handoff", 32'(gnt), 32'h80);
        repeat (2) cyc(8'h00, 1'b0, 1'b0);

        // Solo hold beyond HOLD_MAX
        for (int i = 0; i < 20; i++) begin
            cyc(8'h20, 1'b0, 1'b0);
            check("solo_gnt", 32'(gnt), 32'h20);
        end
        check("solo_sel", 32'(sel), 32'b101);
        repeat (2) cyc(8'h00, 1'b0, 1'b0);

`ifdef ARB_LOCK_EN
        for (int i = 0; i < 10; i++) begin
            cyc(8'h03, 1'b0, 1'b1);
            check("lock_gnt", 32'(gnt), 32'h01);
        end
        cyc(8'h03, 1'b0, 1'b0);
        check("lock_release", 32'(gnt), 32'h02);
        repeat (2) cyc(8'h00, 1'b0, 1'b0);
`endif

        // Randomized traffic
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            cyc(r, ($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
